// File: rtl/scoreboard_pkg.sv
// Shared defaults, counter type and the net-delta helper used by the register scoreboard.
package scoreboard_pkg;

   localparam int DEF_NUM_REGS  = 32;
   localparam int DEF_CNT_WIDTH = 2;
   localparam int IDX_W         = 5;

   typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;

   // Net change of one counter for a cycle: -2 .. +1.
   function automatic logic signed [2:0] net_delta(input logic inc,
                                                   input logic dec_wb,
                                                   input logic dec_kill);
      logic signed [2:0] d;
      d = 3'sd0;
      if (inc)      d = d + 3'sd1;
      if (dec_wb)   d = d - 3'sd1;
      if (dec_kill) d = d - 3'sd1;
      return d;
   endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// Issue / writeback / squash bundle between the pipeline and the decode scoreboard.
interface id_scoreboard_if
   import scoreboard_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS
);
   logic                issue_valid_in;
   logic [IDX_W-1:0]    issue_rs1_in;
   logic [IDX_W-1:0]    issue_rs2_in;
   logic                issue_rs1_used_in;
   logic                issue_rs2_used_in;
   logic [IDX_W-1:0]    issue_rd_in;
   logic                issue_rf_en_in;
   logic                wb_valid_in;
   logic [IDX_W-1:0]    wb_rd_in;
   logic                kill_valid_in;
   logic [IDX_W-1:0]    kill_rd_in;
   logic                flush_all_in;
   logic                stall_out;
   logic [NUM_REGS-1:0] pending_out;
   logic                err_out;

   modport master (
      output issue_valid_in, issue_rs1_in, issue_rs2_in, issue_rs1_used_in,
             issue_rs2_used_in, issue_rd_in, issue_rf_en_in, wb_valid_in,
             wb_rd_in, kill_valid_in, kill_rd_in, flush_all_in,
      input  stall_out, pending_out, err_out
   );

   modport slave (
      input  issue_valid_in, issue_rs1_in, issue_rs2_in, issue_rs1_used_in,
             issue_rs2_used_in, issue_rd_in, issue_rf_en_in, wb_valid_in,
             wb_rd_in, kill_valid_in, kill_rd_in, flush_all_in,
      output stall_out, pending_out, err_out
   );
endinterface

// File: rtl/id_scoreboard_sb_counter.sv
// One per-register pending-write counter: clamps at both ends, flags underflow stickily.
module sb_counter
   import scoreboard_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 clr,
   input  logic                 inc,
   input  logic                 dec_wb,
   input  logic                 dec_kill,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 err
);

   localparam int CNT_MAX = (1 << CNT_WIDTH) - 1;

   int                 sum;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic               under;

   always_comb begin
      sum     = int'(cnt) + int'(net_delta(inc, dec_wb, dec_kill));
      under   = 1'b0;
      cnt_nxt = cnt;
      if (sum < 0) begin
         cnt_nxt = '0;
         under   = 1'b1;
      end else if (sum > CNT_MAX) begin
         cnt_nxt = CNT_WIDTH'(CNT_MAX);
      end else begin
         cnt_nxt = CNT_WIDTH'(sum);
      end
   end

   // A flush wins over every event and never raises the error.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (under) err <= 1'b1;
      end
   end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight writes and stalls readers of pending registers.
module id_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int NUM_REGS  = DEF_NUM_REGS,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic          clk,
   input  logic          arst_n,
   id_scoreboard_if.slave sb
);

   logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
   logic [NUM_REGS-1:1]  err_vec;
   logic                 rs1_haz;
   logic                 rs2_haz;
   logic                 rd_sat;
   logic                 stall;
   logic                 accept;

   assign cnt[0] = '0;

   // Only issue inputs and registered counters feed the stall.
   always_comb begin
      rs1_haz = sb.issue_rs1_used_in && (sb.issue_rs1_in != '0) && (cnt[sb.issue_rs1_in] != '0);
      rs2_haz = sb.issue_rs2_used_in && (sb.issue_rs2_in != '0) && (cnt[sb.issue_rs2_in] != '0);
      rd_sat  = sb.issue_rf_en_in && (sb.issue_rd_in != '0) && (&cnt[sb.issue_rd_in]);
      stall   = sb.issue_valid_in && (rs1_haz || rs2_haz || rd_sat);
   end

   assign accept       = sb.issue_valid_in && !stall;
   assign sb.stall_out = stall;
   assign sb.err_out   = |err_vec;
   assign sb.pending_out[0] = 1'b0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
      logic hit_inc;
      logic hit_wb;
      logic hit_kill;

      assign hit_inc  = accept && sb.issue_rf_en_in && (sb.issue_rd_in == IDX_W'(i));
      assign hit_wb   = sb.wb_valid_in && (sb.wb_rd_in == IDX_W'(i));
      assign hit_kill = sb.kill_valid_in && (sb.kill_rd_in == IDX_W'(i));

      sb_counter #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
         .clk      (clk),
         .arst_n   (arst_n),
         .clr      (sb.flush_all_in),
         .inc      (hit_inc),
         .dec_wb   (hit_wb),
         .dec_kill (hit_kill),
         .cnt      (cnt[i]),
         .err      (err_vec[i])
      );

      assign sb.pending_out[i] = |cnt[i];
   end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed vector table, async-reset sequence and randomized run against a counting model.
module tb_id_scoreboard;
   import scoreboard_pkg::*;

   typedef struct {
      bit        v;
      bit [4:0]  rs1;
      bit        u1;
      bit [4:0]  rs2;
      bit        u2;
      bit [4:0]  rd;
      bit        rf;
      bit        wb;
      bit [4:0]  wbrd;
      bit        kl;
      bit [4:0]  klrd;
      bit        fl;
      bit        e_stall;
      bit [31:0] e_pend;
      bit        e_err;
   } vec_t;

   logic clk;
   logic arst_n;
   int   n_pass;
   int   n_total;
   int   m_cnt [32];
   bit   m_err;
   vec_t tbl [26];

   id_scoreboard_if #(.NUM_REGS(32)) sbi ();

   id_scoreboard dut (
      .clk    (clk),
      .arst_n (arst_n),
      .sb     (sbi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input vec_t t);
      sbi.issue_valid_in    = t.v;
      sbi.issue_rs1_in      = t.rs1;
      sbi.issue_rs1_used_in = t.u1;
      sbi.issue_rs2_in      = t.rs2;
      sbi.issue_rs2_used_in = t.u2;
      sbi.issue_rd_in       = t.rd;
      sbi.issue_rf_en_in    = t.rf;
      sbi.wb_valid_in       = t.wb;
      sbi.wb_rd_in          = t.wbrd;
      sbi.kill_valid_in     = t.kl;
      sbi.kill_rd_in        = t.klrd;
      sbi.flush_all_in      = t.fl;
   endtask

   function automatic bit model_stall(input vec_t t);
      bit h;
      h = (t.u1 && t.rs1 != 0 && m_cnt[t.rs1] > 0) ||
          (t.u2 && t.rs2 != 0 && m_cnt[t.rs2] > 0) ||
          (t.rf && t.rd != 0 && m_cnt[t.rd] == 3);
      return t.v && h;
   endfunction

   function automatic bit [31:0] model_pend();
      bit [31:0] p;
      p = '0;
      for (int r = 1; r < 32; r++) p[r] = (m_cnt[r] > 0);
      return p;
   endfunction

   task automatic model_update(input vec_t t, input bit acc);
      int d;
      int n;
      if (t.fl) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            d = 0;
            if (acc && t.rf && t.rd == r) d++;
            if (t.wb && t.wbrd == r) d--;
            if (t.kl && t.klrd == r) d--;
            n = m_cnt[r] + d;
            if (n < 0) begin
               n = 0;
               m_err = 1'b1;
            end
            if (n > 3) n = 3;
            m_cnt[r] = n;
         end
      end
   endtask

   initial begin
      vec_t t;
      vec_t idle;
      bit   ms;
      n_pass  = 0;
      n_total = 0;
      m_err   = 1'b0;
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      idle = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};

      //         v rs1 u1 rs2 u2 rd rf wb wbrd kl klrd fl  stall pend       err
      tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 32'h0,     0};
      tbl[1]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20,    0};
      tbl[2]  = '{1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 32'h20,    0};
      tbl[3]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,     0};
      tbl[4]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,     0};
      tbl[5]  = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,     0};
      tbl[6]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,     0};
      tbl[7]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h80,    0};
      tbl[8]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h80,    0};
      tbl[9]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 32'h80,    0};
      tbl[10] = '{1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0, 0, 1, 32'h80,    0};
      tbl[11] = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 32'h80,    0};
      tbl[12] = '{1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 32'h80,    0};
      tbl[13] = '{1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 0, 0, 0, 32'h280,   0};
      tbl[14] = '{1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h280,   0};
      tbl[15] = '{1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 32'h280,   0};
      tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 32'h280,   0};
      tbl[17] = '{1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80,    0};
      tbl[18] = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 32'h80,    0};
      tbl[19] = '{1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 32'h88,    0};
      tbl[20] = '{1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 0, 32'h98,    0};
      tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,     0};
      tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 32'h0,     0};
      tbl[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,     1};
      tbl[24] = '{1, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0,     1};
      tbl[25] = '{0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h08,    1};

      // Reset state, with a would-be hazard on the issue inputs.
      arst_n = 1'b0;
      drive(idle);
      sbi.issue_valid_in    = 1'b1;
      sbi.issue_rs1_in      = 5'd1;
      sbi.issue_rs1_used_in = 1'b1;
      #12;
      chk("reset_stall", 32'(sbi.stall_out), 32'h0);
      chk("reset_pending", sbi.pending_out, 32'h0);
      chk("reset_err", 32'(sbi.err_out), 32'h0);
      #1 arst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i]);
         #2;
         chk($sformatf("tbl%0d_stall", i), 32'(sbi.stall_out), 32'(tbl[i].e_stall));
         chk($sformatf("tbl%0d_pending", i), sbi.pending_out, tbl[i].e_pend);
         chk($sformatf("tbl%0d_err", i), 32'(sbi.err_out), 32'(tbl[i].e_err));
         @(posedge clk); #1;
      end

      // Build cnt[2]=2 then pull reset between edges.
      t = idle;
      t.v = 1; t.rd = 2; t.rf = 1;
      drive(t);
      @(posedge clk); #1;
      @(posedge clk); #1;
      t = idle;
      t.v = 1; t.rs1 = 2; t.u1 = 1;
      drive(t);
      #1;
      chk("pre_rst_stall", 32'(sbi.stall_out), 32'h1);
      chk("pre_rst_pending", sbi.pending_out, 32'h0C);
      #1 arst_n = 1'b0;
      #1;
      chk("async_rst_stall", 32'(sbi.stall_out), 32'h0);
      chk("async_rst_pending", sbi.pending_out, 32'h0);
      chk("async_rst_err", 32'(sbi.err_out), 32'h0);
      #1 arst_n = 1'b1;
      drive(idle);
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 1'b0;
      @(posedge clk); #1;

      for (int c = 0; c < 400; c++) begin
         t = idle;
         t.v    = ($urandom_range(99) < 70);
         t.rs1  = 5'($urandom_range(7));
         t.u1   = 1'($urandom);
         t.rs2  = 5'($urandom_range(7));
         t.u2   = 1'($urandom);
         t.rd   = 5'($urandom_range(7));
         t.rf   = ($urandom_range(99) < 75);
         t.wb   = ($urandom_range(99) < 35);
         t.wbrd = 5'($urandom_range(7));
         t.kl   = ($urandom_range(99) < 10);
         t.klrd = 5'($urandom_range(7));
         t.fl   = ($urandom_range(99) < 3);
         drive(t);
         #2;
         ms = model_stall(t);
         chk("rand_stall", 32'(sbi.stall_out), 32'(ms));
         chk("rand_pending", sbi.pending_out, model_pend());
         chk("rand_err", 32'(sbi.err_out), 32'(m_err));
         @(posedge clk);
         model_update(t, t.v && !ms);
         #1;
      end

      drive(idle);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
